// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - asynchronous SRAM initiator with registered strobes
// One CPU request at a time; the strobes are flops loaded from the decoded next state.
module sram_controller #(
  parameter int WaitStates = 1,
  parameter int AddrWidth  = 20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           ByteEn,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [15:0]          WrData,
  output logic [15:0]          RdData,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 CE,
  output logic                 OE,
  output logic                 WE,
  output logic                 LB,
  output logic                 UB,
  output logic [19:0]          ADDR,
  inout  wire  [15:0]          DQ
);

  localparam int CntW = $clog2(WaitStates + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(WaitStates);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    st_idle, st_rd, st_wsetup, st_wpulse, st_whold, st_done
  } state_t;

  state_t          state, next_state;
  logic [CntW-1:0] wait_cnt;
  logic [1:0]      be_q;
  logic [15:0]     wr_data_q;
  logic            dq_oe;
  logic            wait_done, accept;
  logic [1:0]      be_nxt;
  logic            ce_d, oe_d, we_d, lb_d, ub_d, dq_oe_d, ready_d, busy_d;

  assign wait_done = (wait_cnt == LastCnt);
  assign accept    = (state == st_idle) && (next_state != st_idle);
  // Byte strobes for the first access cycle must come from the request itself.
  assign be_nxt    = accept ? ByteEn : be_q;
  assign DQ        = dq_oe ? wr_data_q : 16'hzzzz;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= st_idle;
      wait_cnt  <= '0;
      be_q      <= 2'b00;
      wr_data_q <= 16'h0000;
      ADDR      <= 20'h00000;
      RdData    <= 16'h0000;
      CE        <= 1'b1;
      OE        <= 1'b1;
      WE        <= 1'b1;
      LB        <= 1'b1;
      UB        <= 1'b1;
      dq_oe     <= 1'b0;
      Ready     <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (next_state != state) ? '0 : wait_cnt + CntOne;
      if (accept) begin
        be_q      <= ByteEn;
        wr_data_q <= WrData;
        ADDR      <= 20'(Addr);
      end
      if (state == st_rd && wait_done)
        RdData <= DQ & {{8{be_q[1]}}, {8{be_q[0]}}};
      CE    <= ce_d;
      OE    <= oe_d;
      WE    <= we_d;
      LB    <= lb_d;
      UB    <= ub_d;
      dq_oe <= dq_oe_d;
      Ready <= ready_d;
      Busy  <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      st_idle:   if (MemWrite) next_state = st_wsetup;
                 else if (MemRead) next_state = st_rd;
      st_rd:     if (wait_done) next_state = st_done;
      st_wsetup: next_state = st_wpulse;
      st_wpulse: if (wait_done) next_state = st_whold;
      st_whold:  next_state = st_done;
      st_done:   next_state = st_idle;
      default:   next_state = st_idle;
    endcase
  end

  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    dq_oe_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = (next_state != st_idle);
    case (next_state)
      st_rd: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        lb_d = ~be_nxt[0];
        ub_d = ~be_nxt[1];
      end
      st_wsetup, st_wpulse, st_whold: begin
        ce_d    = 1'b0;
        we_d    = (next_state != st_wpulse);
        lb_d    = ~be_nxt[0];
        ub_d    = ~be_nxt[1];
        dq_oe_d = 1'b1;
      end
      st_done: ready_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench for sram_controller with a small SRAM model
module tb_sram_controller;

  logic        Clk, Reset, MemRead, MemWrite;
  logic [1:0]  ByteEn;
  logic [19:0] Addr;
  logic [15:0] WrData, RdData;
  logic        Ready, Busy, CE, OE, WE, LB, UB;
  logic [19:0] ADDR;
  wire  [15:0] DQ;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:15];
  logic        ready_q;
  int          lat, wl, bl, rdy, bad;
  logic [15:0] dqp;

  sram_controller #(.WaitStates(1), .AddrWidth(20)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ByteEn(ByteEn), .Addr(Addr), .WrData(WrData), .RdData(RdData),
    .Ready(Ready), .Busy(Busy), .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB),
    .ADDR(ADDR), .DQ(DQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: drives the full word while read-selected, writes enabled lanes while WE is low.
  assign DQ = (CE == 1'b0 && OE == 1'b0) ? mem[ADDR[3:0]] : 16'hzzzz;

  initial for (int i = 0; i < 16; i++) mem[i] <= 16'(16'h1111 * i);

  always @(posedge Clk) begin
    if (CE == 1'b0 && WE == 1'b0) begin
      if (!LB) mem[ADDR[3:0]][7:0]  <= DQ[7:0];
      if (!UB) mem[ADDR[3:0]][15:8] <= DQ[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      chk("oe_we_exclusive", {31'd0, !(OE == 1'b0 && WE == 1'b0)}, 32'd1);
      if (Ready) chk("ready_needs_busy", {31'd0, Busy}, 32'd1);
      chk("ready_one_cycle", {31'd0, !(Ready && ready_q)}, 32'd1);
      ready_q = Ready;
    end else begin
      ready_q = 1'b0;
    end
  end

  // One transaction; lat counts sampled cycles after the accepting edge up to and including Ready.
  task automatic xact(input logic wr, input logic [19:0] a, input logic [15:0] d,
                      input logic [1:0] be, output int l, output int w, output int b,
                      output logic [15:0] dq_at_pulse);
    @(negedge Clk);
    Addr = a; WrData = d; ByteEn = be; MemWrite = wr; MemRead = !wr;
    @(posedge Clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    l = 0; w = 0; b = 0; dq_at_pulse = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      l++;
      if (!WE) w++;
      if (!LB || !UB) b++;
      if (!WE && w == 1) dq_at_pulse = DQ;
      if (Ready) break;
      @(posedge Clk); #1;
    end
    if (Ready) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ByteEn = 2'b00; Addr = 20'h0; WrData = 16'h0; ready_q = 1'b0;

    #12;
    chk("reset_strobes", {27'd0, CE, OE, WE, LB, UB}, 32'h1f);
    chk("reset_flags", {30'd0, Ready, Busy}, 32'h0);
    chk("reset_rddata", {16'd0, RdData}, 32'h0);
    chk("reset_addr", {12'd0, ADDR}, 32'h0);

    @(negedge Clk) Reset = 1'b1;
    rdy = 0; bad = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      rdy += int'(Ready);
      if ({CE, OE, WE, LB, UB} != 5'h1f) bad++;
    end
    chk("idle_ready_count", rdy, 0);
    chk("idle_strobe_activity", bad, 0);
    chk("idle_rddata", {16'd0, RdData}, 32'h0);

    xact(1'b1, 20'd3, 16'hBEEF, 2'b11, lat, wl, bl, dqp);
    chk("wr_latency", lat, 5);
    chk("wr_we_low_cycles", wl, 2);
    chk("wr_dq_value", {16'd0, dqp}, 32'hBEEF);
    chk("wr_addr_out", {12'd0, ADDR}, 32'd3);
    xact(1'b0, 20'd3, 16'h0000, 2'b11, lat, wl, bl, dqp);
    chk("rd_latency", lat, 3);
    chk("rd_we_low_cycles", wl, 0);
    chk("rd_data_beef", {16'd0, RdData}, 32'hBEEF);

    xact(1'b1, 20'd5, 16'h1234, 2'b11, lat, wl, bl, dqp);
    xact(1'b1, 20'd5, 16'hAB00, 2'b10, lat, wl, bl, dqp);
    chk("upper_wr_dq", {16'd0, dqp}, 32'hAB00);
    xact(1'b0, 20'd5, 16'h0000, 2'b11, lat, wl, bl, dqp);
    chk("merge_rd_full", {16'd0, RdData}, 32'hAB34);
    xact(1'b0, 20'd5, 16'h0000, 2'b01, lat, wl, bl, dqp);
    chk("merge_rd_lower", {16'd0, RdData}, 32'h0034);
    xact(1'b0, 20'd5, 16'h0000, 2'b00, lat, wl, bl, dqp);
    chk("noen_rd_data", {16'd0, RdData}, 32'h0);
    chk("noen_rd_latency", lat, 3);
    chk("noen_byte_strobes", bl, 0);

    @(negedge Clk);
    Addr = 20'd7; WrData = 16'h5A5A; ByteEn = 2'b11; MemWrite = 1'b1; MemRead = 1'b1;
    @(posedge Clk); #1;
    chk("both_req_is_write", {30'd0, OE, CE}, 32'h2);
    for (int k = 1; k <= 3; k++) begin
      MemRead = k[0]; MemWrite = !k[0]; Addr = 20'd9; WrData = 16'hFFFF;
      @(posedge Clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    rdy = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      rdy += int'(Ready);
    end
    chk("both_req_ready_count", rdy, 1);
    xact(1'b0, 20'd7, 16'h0000, 2'b11, lat, wl, bl, dqp);
    chk("both_req_data", {16'd0, RdData}, 32'h5A5A);
    xact(1'b0, 20'd9, 16'h0000, 2'b11, lat, wl, bl, dqp);
    chk("busy_req_ignored", {16'd0, RdData}, 32'h9999);

    @(negedge Clk);
    Addr = 20'd11; WrData = 16'hC0DE; ByteEn = 2'b11; MemWrite = 1'b1;
    @(posedge Clk); #1;
    MemWrite = 1'b0;
    @(posedge Clk); #1;
    chk("pulse_before_reset", {31'd0, WE}, 32'd0);
    Reset = 1'b0; #1;
    chk("midreset_strobes", {27'd0, CE, OE, WE, LB, UB}, 32'h1f);
    chk("midreset_flags", {30'd0, Ready, Busy}, 32'h0);
    @(negedge Clk) Reset = 1'b1;
    rdy = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      rdy += int'(Ready);
    end
    chk("midreset_no_ready", rdy, 0);
    xact(1'b0, 20'd11, 16'h0000, 2'b11, lat, wl, bl, dqp);
    chk("after_reset_rd_latency", lat, 3);
    chk("after_reset_rd_data", {31'd0, (RdData == 16'hBBBB || RdData == 16'hC0DE)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
